// File: rtl/seq_checker.sv
// seq_checker: downstream monitor for a WIDTH-bit incrementing data stream.
// Locks onto a modulo-2^WIDTH incrementing sequence after SYNC_LEN
// consecutive in-sequence samples, then flags every deviation, keeps
// saturating sample/error counts and the last offending value.
// Optional build macro SEQ_CHK_ERR_LOG_EN adds a 4-entry {expected, received}
// error log FIFO with log_rd/log_vld/log_data ports.
module seq_checker #(
    parameter int WIDTH    = 4,
    parameter int CNT_W    = 16,
    parameter int SYNC_LEN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   din,
`ifdef SEQ_CHK_ERR_LOG_EN
    input  logic               log_rd,
    output logic               log_vld,
    output logic [2*WIDTH-1:0] log_data,
`endif
    output logic               locked,
    output logic               err,
    output logic               err_sticky,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [WIDTH-1:0]   exp_val,
    output logic [WIDTH-1:0]   last_bad
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    // Threshold widened by one bit so the run+1 comparison cannot wrap.
    localparam logic [4:0] SYNC_LEN_C = 5'(SYNC_LEN);

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Successor of a value in the checked sequence (wraps modulo 2^WIDTH).
    function automatic logic [WIDTH-1:0] seq_next(input logic [WIDTH-1:0] v);
        return v + WIDTH'(1);
    endfunction

    state_t             state_q;
    logic [3:0]         run_q;
    logic [WIDTH-1:0]   exp_q;
    logic [WIDTH-1:0]   bad_q;
    logic [CNT_W-1:0]   scnt_q;
    logic [CNT_W-1:0]   ecnt_q;
    logic               locked_q;
    logic               err_q;
    logic               sticky_q;

    logic               seq_hit;
    logic               lock_miss;
    logic [4:0]         run_d;
    logic               sync_done;

    // Sample classification shared by the FSM and the error log.
    always_comb begin
        seq_hit   = (din == exp_q);
        lock_miss = en && (state_q == LOCK) && !seq_hit;
        run_d     = {1'b0, run_q} + 5'd1;
        sync_done = (run_d >= SYNC_LEN_C);
    end

    // Checker FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            run_q    <= 4'd0;
            exp_q    <= '0;
            bad_q    <= '0;
            scnt_q   <= '0;
            ecnt_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (en) begin
                case (state_q)
                    IDLE: begin
                        exp_q <= seq_next(din);
                        run_q <= 4'd1;
                        if (SYNC_LEN == 1) begin
                            state_q  <= LOCK;
                            locked_q <= 1'b1;
                        end else begin
                            state_q  <= SYNC;
                            locked_q <= 1'b0;
                        end
                    end
                    SYNC: begin
                        // Either way the next expectation follows the received value.
                        exp_q <= seq_next(din);
                        if (seq_hit) begin
                            run_q <= run_d[3:0];
                            if (sync_done) begin
                                state_q  <= LOCK;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            run_q <= 4'd1;
                        end
                    end
                    LOCK: begin
                        scnt_q <= sat_inc(scnt_q);
                        if (seq_hit) begin
                            exp_q <= seq_next(exp_q);
                        end else begin
                            // Report, then resynchronise on the value just received.
                            err_q    <= 1'b1;
                            sticky_q <= 1'b1;
                            ecnt_q   <= sat_inc(ecnt_q);
                            bad_q    <= din;
                            exp_q    <= seq_next(din);
                            run_q    <= 4'd1;
                            state_q  <= SYNC;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign sample_cnt = scnt_q;
    assign err_cnt    = ecnt_q;
    assign exp_val    = exp_q;
    assign last_bad   = bad_q;

`ifdef SEQ_CHK_ERR_LOG_EN
    logic [2*WIDTH-1:0] mem_q [4];
    logic [1:0]         wr_q;
    logic [1:0]         rd_q;
    logic [2:0]         cnt_q;
    logic [2:0]         cnt_d;
    logic               pop;
    logic               push_ok;

    // A pop frees a slot in the same edge, so a full FIFO can still accept a push then.
    always_comb begin
        pop     = log_rd && (cnt_q != 3'd0);
        push_ok = lock_miss && ((cnt_q != 3'd4) || pop);
        cnt_d   = cnt_q + {2'b00, push_ok} - {2'b00, pop};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 2'd0;
            rd_q  <= 2'd0;
            cnt_q <= 3'd0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + 2'd1;
            end
            if (pop) begin
                rd_q <= rd_q + 2'd1;
            end
            cnt_q <= cnt_d;
        end
    end

    // Log storage; entries are only read while valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_q] <= {exp_q, din};
        end
    end

    assign log_vld  = (cnt_q != 3'd0);
    assign log_data = mem_q[rd_q];
`endif

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Downstream consumer of the 4-bit registered flop output; samples the output stream each qualified clock.
- Locks onto an incrementing sequence, then flags every deviation from it.
- Keeps saturating sample and error counts and the last offending value for the simulation monitor.
- Pure synchronous checker; drives nothing back into the datapath.

Parameters:
WIDTH, 4, width of checked data (matches flop q width)
CNT_W, 16, width of sample and error counters
SYNC_LEN, 2, consecutive in-sequence samples required to reach LOCK (legal range 1..15)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  reset, synchronous, active-high
en  input  1  sample qualifier; din is ignored when low
din  input  WIDTH  data from upstream flop q
locked  output  1  high while FSM in LOCK
err  output  1  one-cycle pulse per mismatch detected in LOCK
err_sticky  output  1  set by first err, cleared only by rst
sample_cnt  output  CNT_W  en samples taken while in LOCK, saturating
err_cnt  output  CNT_W  mismatches detected, saturating
exp_val  output  WIDTH  value expected on next en sample
last_bad  output  WIDTH  din value of most recent mismatch

Behaviour:
- Reset (rst high at posedge): state IDLE, run=0; locked=0, err=0, err_sticky=0, sample_cnt=0, err_cnt=0, exp_val=0, last_bad=0.
- rst takes priority over en at the same edge; rst asserted mid-LOCK discards all state in one cycle.
- All outputs registered; effects of a sample at edge k are visible after edge k.
- Sequence arithmetic is modulo 2^WIDTH: exp_val is always din+1 truncated to WIDTH. 4'hF followed by 4'h0 is in sequence.
- Edges with en=0: no state, counter, or output change, except err, which returns to 0.
- FSM states IDLE, SYNC, LOCK; run is a 4-bit in-sequence run counter.
- IDLE, en: exp_val<=din+1, run<=1. Next state is LOCK if SYNC_LEN==1, else SYNC.
- SYNC, en, din==exp_val: exp_val<=din+1, run<=run+1. Next state is LOCK when run+1==SYNC_LEN.
- SYNC, en, din!=exp_val: exp_val<=din+1, run<=1, stay SYNC. No err and no counting in SYNC.
- LOCK, en: sample_cnt increments, holding at all-ones.
- LOCK, en, din==exp_val: exp_val<=exp_val+1, stay LOCK.
- LOCK, en, din!=exp_val:
  - err<=1 for one cycle; err_sticky<=1.
  - err_cnt increments, holding at all-ones; last_bad<=din.
  - Resync on the received value: exp_val<=din+1, run<=1, go SYNC, so locked drops after the same edge.
- Repeated value while locked (for example upstream held in reset) counts as a mismatch.
- locked = (state==LOCK), registered.

Optional Feature:
SEQ_CHK_ERR_LOG_EN
- Defined: adds a 4-entry error log FIFO and three ports:
  - log_rd  input  1
  - log_vld  output  1
  - log_data  output  2*WIDTH, holding {expected, received}
- Each LOCK mismatch pushes one entry. When the FIFO is full, the push is dropped and the oldest entries are kept.
- log_vld is high when the FIFO is not empty; log_data shows the head entry.
- log_rd with log_vld high pops the head. log_rd while empty is ignored.
- A simultaneous push and pop on a full FIFO performs both.
- Reset empties the FIFO.
- Undefined: no FIFO and no extra ports; core behaviour is identical.

Test Plan:
- Lock: rst for 2 cycles, then en=1 with din=3,4,5,6 -> locked=0 after 3, 1 after 4; sample_cnt=2 after 6; exp_val=7; err never high.
- Wrap: after lock, din=E,F,0,1 -> no err; exp_val=2 at end; err_cnt=0.
- Mismatch and resync: locked at exp_val=5, din=9 -> err pulses 1 cycle; err_cnt=1; last_bad=9; locked=0; err_sticky=1. Then din=A,B -> locked=1 again with exp_val=C.
- en gating: locked at exp_val=2, en=0 for 5 cycles with random din, then en=1 din=2 -> no err; sample_cnt increments by exactly 1.
- Reset mid-LOCK: locked, err_cnt=3, assert rst one cycle -> all outputs 0 next cycle; err_sticky=0; state IDLE.
- SEQ_CHK_ERR_LOG_EN: 6 mismatches with no reads -> log_vld=1; 4 pops return the first 4 {exp,got} pairs in order; log_vld=0 afterwards.
